ahb_lite_cmd_master: RTL and testbench

//  AHB-Lite single-master front end that drives the SRAM controller slave port (hsel/haddr/htrans/hwrite/hsize/hwdata).

---
 rtl/ahb_lite_master_pkg.sv | 27 ++
 rtl/ahbm_cmd_fifo.sv | 55 +++++
 rtl/ahb_lite_cmd_master.sv | 204 ++++++++++++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and the queued command record for ahb_lite_cmd_master.
// Widths here bound the top-level ADDR_W/DATA_W parameters.
package ahb_lite_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int AHBM_ADDR_W = 32;
    localparam int AHBM_DATA_W = 32;

    typedef struct packed {
        logic                   write;
        logic [1:0]             size;
        logic [AHBM_ADDR_W-1:0] addr;
        logic [AHBM_DATA_W-1:0] wdata;
    } ahbm_cmd_t;

    // The illegal size code 3 is driven on the bus as a word transfer.
    function automatic logic [2:0] ahbm_hsize(input logic [1:0] size);
        return (size == 2'd3) ? HSIZE_WORD : {1'b0, size};
    endfunction

endpackage

// File: rtl/ahbm_cmd_fifo.sv
// First-word-fall-through command FIFO for ahb_lite_cmd_master.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ahbm_cmd_fifo
    import ahb_lite_master_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ahbm_cmd_t push_cmd,
    input  logic      pop,
    output ahbm_cmd_t head,
    output logic      empty,
    output logic      full
);

    localparam int             PTR_W   = $clog2(CMD_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           push_en, pop_en;
    ahbm_cmd_t      mem_q [CMD_DEPTH];

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        // A push while full is dropped even if a pop frees a slot this edge.
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = push_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_en  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_cmd;
        end
    end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-master front end: queued commands issued as pipelined NONSEQ singles.
// Optional macro AHBM_ERR_CAPTURE_EN enables ERROR handling, rsp_err and sticky error capture.
module ahb_lite_cmd_master
    import ahb_lite_master_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    output logic              hready,
    input  logic              hready_resp,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              err_clr,
    output logic              err_flag,
    output logic [ADDR_W-1:0] err_addr
);

    ahbm_cmd_t cmd_in, fifo_head, a_src;
    logic      fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic      push_acc, load_ok, bypass, complete, err_pend;

    logic              ready_en_q, ready_en_d;
    logic              a_valid_q, a_valid_d;
    logic              a_write_q, a_write_d;
    logic [2:0]        a_size_q, a_size_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    ahbm_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
        .clk      (hclk),
        .rst_n    (hresetn),
        .push     (fifo_push),
        .push_cmd (cmd_in),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        cmd_in.write = cmd_write;
        cmd_in.size  = cmd_size;
        cmd_in.addr  = AHBM_ADDR_W'(cmd_addr);
        cmd_in.wdata = AHBM_DATA_W'(cmd_wdata);

        push_acc  = cmd_valid && cmd_ready;
        load_ok   = hready_resp && !err_pend;
        // An empty FIFO hands the new command straight to the address stage.
        bypass    = fifo_empty && push_acc && load_ok;
        fifo_push = push_acc && !bypass;
        fifo_pop  = load_ok && !fifo_empty;
        a_src     = fifo_empty ? cmd_in : fifo_head;
        complete  = d_valid_q && hready_resp;

        ready_en_d = 1'b1;
        a_valid_d  = a_valid_q;
        a_write_d  = a_write_q;
        a_size_d   = a_size_q;
        a_addr_d   = a_addr_q;
        a_wdata_d  = a_wdata_q;
        d_valid_d  = d_valid_q;
        d_write_d  = d_write_q;
        d_wdata_d  = d_wdata_q;

        if (hready_resp) begin
            d_valid_d = a_valid_q;
            d_write_d = a_write_q;
            d_wdata_d = a_wdata_q;
            a_valid_d = 1'b0;
            if (fifo_pop || bypass) begin
                a_valid_d = 1'b1;
                a_write_d = a_src.write;
                a_size_d  = ahbm_hsize(a_src.size);
                a_addr_d  = ADDR_W'(a_src.addr);
                a_wdata_d = DATA_W'(a_src.wdata);
            end
        end

        rsp_valid_d = complete;
        rsp_write_d = complete && d_write_q;
        rsp_rdata_d = (complete && !d_write_q) ? hrdata : '0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ready_en_q  <= 1'b0;
            a_valid_q   <= 1'b0;
            a_write_q   <= 1'b0;
            a_size_q    <= '0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            a_valid_q   <= a_valid_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_addr_q    <= a_addr_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef AHBM_ERR_CAPTURE_EN
    logic              err_pend_q, err_pend_d;
    logic              rsp_err_q, rsp_err_d;
    logic              err_flag_q, err_flag_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;

    always_comb begin
        // First ERROR cycle arms an IDLE insertion for the edge that ends the response.
        err_pend_d = hready_resp ? 1'b0 : (err_pend_q || (d_valid_q && hresp));
        d_addr_d   = hready_resp ? a_addr_q : d_addr_q;
        rsp_err_d  = complete && hresp;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            err_flag_d = 1'b0;
        end else if (complete && hresp && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_addr_d = d_addr_q;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_pend_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
            d_addr_q   <= '0;
        end else begin
            err_pend_q <= err_pend_d;
            rsp_err_q  <= rsp_err_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
            d_addr_q   <= d_addr_d;
        end
    end

    assign err_pend = err_pend_q;
    assign rsp_err  = rsp_err_q;
    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;
`else
    logic unused_err_inputs;
    assign unused_err_inputs = hresp ^ err_clr;
    assign err_pend = 1'b0;
    assign rsp_err  = 1'b0;
    assign err_flag = 1'b0;
    assign err_addr = '0;
`endif

    assign cmd_ready = ready_en_q && !fifo_full;
    assign busy      = !fifo_empty || a_valid_q || d_valid_q;
    assign hsel      = a_valid_q;
    assign haddr     = a_addr_q;
    assign htrans    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite    = a_write_q;
    assign hsize     = a_size_q;
    assign hwdata    = d_wdata_q;
    assign hready    = hready_resp;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Scoreboard bench for ahb_lite_cmd_master with a small AHB SRAM slave model.
`timescale 1ns/1ps
module tb_ahb_lite_cmd_master;
    import ahb_lite_master_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_write, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        hsel, hwrite, hready, hready_resp, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        err_clr = 1'b0;
    logic        err_flag;
    logic [31:0] err_addr;

    always #5 hclk = ~hclk;

    ahb_lite_cmd_master dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
        .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr)
    );

    // SRAM slave model; an armed address answers with a two-cycle ERROR.
    logic        hready_drv = 1'b1;
    logic        err_arm = 1'b0;
    logic [31:0] err_at = '0;
    logic [31:0] mem [0:63];
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;
    logic [1:0]  err_st;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    assign hready_resp = hready_drv && (err_st != 2'd1);
    assign hresp       = (err_st != 2'd0);
    assign hrdata      = (dp_valid && !dp_write) ? mem[dp_addr[7:2]] : 32'h0;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= '0;
            err_st   <= 2'd0;
        end else if (err_st == 2'd1) begin
            err_st <= 2'd2;
        end else if (hready_resp) begin
            if (dp_valid && dp_write && err_st == 2'd0) begin
                case (dp_size)
                    3'd0:    mem[dp_addr[7:2]][8*dp_addr[1:0] +: 8]  <= hwdata[8*dp_addr[1:0] +: 8];
                    3'd1:    mem[dp_addr[7:2]][16*dp_addr[1] +: 16]  <= hwdata[16*dp_addr[1] +: 16];
                    default: mem[dp_addr[7:2]] <= hwdata;
                endcase
            end
            dp_valid <= hsel && (htrans == HTRANS_NONSEQ);
            dp_write <= hwrite;
            dp_addr  <= haddr;
            dp_size  <= hsize;
            err_st   <= (hsel && htrans == HTRANS_NONSEQ && err_arm && haddr == err_at) ? 2'd1 : 2'd0;
        end
    end

    always @(posedge hclk) begin
        if (hresetn && cmd_valid && cmd_ready)
            assert (cmd_size != 2'd3) else $error("illegal cmd_size 3 pushed");
    end

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every response pops the oldest expectation.
    always @(negedge hclk) begin
        if (hresetn && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_write", {31'd0, rsp_write}, {31'd0, mon_e.w});
                chk("rsp_rdata", rsp_rdata, mon_e.d);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.e});
            end
        end
        if (hready) begin
            if (hsel && htrans == HTRANS_NONSEQ) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    task automatic push(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = wd;
        while (!cmd_ready && n < 100) begin
            @(negedge hclk);
            n++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back('{w, exp_d, exp_e});
            @(negedge hclk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge hclk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_trans;
    logic        saw_rsp;

    initial begin
        // Reset state.
        repeat (3) @(negedge hclk);
        chk("rst_hsel", {31'd0, hsel}, 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_hwrite_hsize", {28'd0, hwrite, hsize}, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_write, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy_ready", {30'd0, busy, cmd_ready}, 32'd0);
        chk("rst_err", {31'd0, err_flag}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        hresetn = 1'b1;
        @(negedge hclk);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Single write then read with latency checks.
        push(1'b1, 2'd2, 32'h10, 32'hA5A51234, 32'h0, 1'b0);
        chk("t2_w_htrans", {30'd0, htrans}, {30'd0, HTRANS_NONSEQ});
        chk("t2_w_haddr", haddr, 32'h10);
        chk("t2_w_dir_size", {28'd0, hwrite, hsize}, {28'd0, 1'b1, HSIZE_WORD});
        @(negedge hclk);
        chk("t2_w_hwdata", hwdata, 32'hA5A51234);
        @(negedge hclk);
        chk("t2_w_rsp_lat", {31'd0, rsp_valid}, 32'd1);
        push(1'b0, 2'd2, 32'h10, 32'h0, 32'hA5A51234, 1'b0);
        chk("t2_r_htrans", {30'd0, htrans}, {30'd0, HTRANS_NONSEQ});
        chk("t2_r_hwrite", {31'd0, hwrite}, 32'd0);
        repeat (2) @(negedge hclk);
        chk("t2_r_rsp_lat", {31'd0, rsp_valid}, 32'd1);
        drain();

        // Back-to-back burst of four writes and four reads.
        for (int i = 0; i < 4; i++)
            push(1'b1, 2'd2, 32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0101, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            push(1'b0, 2'd2, 32'(4 * i), 32'h0, 32'h1000_0000 + 32'(i) * 32'h0101, 1'b0);
        drain();
        chk("t3_nonseq_run", max_run, 32'd8);

        // Two-cycle wait state mid-burst with six commands.
        fork
            begin
                for (int i = 0; i < 3; i++)
                    push(1'b1, 2'd2, 32'h80 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 32'h0, 1'b0);
                for (int i = 0; i < 3; i++)
                    push(1'b0, 2'd2, 32'h80 + 32'(4 * i), 32'h0, 32'hC0DE_0000 + 32'(i), 1'b0);
            end
            begin
                repeat (2) @(negedge hclk);
                hready_drv = 1'b0;
                s_addr  = haddr;
                s_trans = htrans;
                s_wdata = hwdata;
                repeat (2) begin
                    @(negedge hclk);
                    chk("t4_haddr_stable", haddr, s_addr);
                    chk("t4_htrans_stable", {30'd0, htrans}, {30'd0, s_trans});
                    chk("t4_hwdata_stable", hwdata, s_wdata);
                end
                hready_drv = 1'b1;
            end
        join
        drain();

        // Long stall fills the FIFO.
        hready_drv = 1'b0;
        for (int i = 0; i < 4; i++)
            push(1'b0, 2'd2, 32'(4 * i), 32'h0, 32'h1000_0000 + 32'(i) * 32'h0101, 1'b0);
        chk("t4_full_not_ready", {31'd0, cmd_ready}, 32'd0);
        chk("t4_full_idle_bus", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
        chk("t4_full_busy", {31'd0, busy}, 32'd1);
        hready_drv = 1'b1;
        drain();
        chk("t4_ready_again", {31'd0, cmd_ready}, 32'd1);

        // Byte write into a zeroed word.
        push(1'b1, 2'd2, 32'h20, 32'h0, 32'h0, 1'b0);
        push(1'b1, 2'd0, 32'h23, 32'h7700_0000, 32'h0, 1'b0);
        chk("t5_byte_haddr", haddr, 32'h23);
        chk("t5_byte_hsize", {29'd0, hsize}, {29'd0, HSIZE_BYTE});
        push(1'b0, 2'd2, 32'h20, 32'h0, 32'h7700_0000, 1'b0);
        drain();

`ifdef AHBM_ERR_CAPTURE_EN
        // Two-cycle ERROR on a write, followed by a read that must still complete.
        err_at  = 32'h40;
        err_arm = 1'b1;
        push(1'b1, 2'd2, 32'h40, 32'h1234_5678, 32'h0, 1'b1);
        push(1'b0, 2'd2, 32'h44, 32'h0, 32'h0, 1'b0);
        drain();
        err_arm = 1'b0;
        chk("t6_err_flag", {31'd0, err_flag}, 32'd1);
        chk("t6_err_addr", err_addr, 32'h40);
        err_clr = 1'b1;
        @(negedge hclk);
        err_clr = 1'b0;
        chk("t6_err_clr", {31'd0, err_flag}, 32'd0);
        chk("t6_err_addr_held", err_addr, 32'h40);
        push(1'b0, 2'd2, 32'h40, 32'h0, 32'h0, 1'b0);
        drain();
`endif

        // Reset during a read data phase discards it.
        push(1'b0, 2'd2, 32'h10, 32'h0, 32'hA5A51234, 1'b0);
        @(negedge hclk);
        hresetn = 1'b0;
        exp_q.delete();
        @(negedge hclk);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_htrans", {30'd0, htrans}, 32'd0);
        hresetn = 1'b1;
        saw_rsp = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        chk("t6_rst_no_rsp", {31'd0, saw_rsp}, 32'd0);
        chk("t6_rst_fifo_empty", {30'd0, busy, cmd_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
